// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, line/frame phase type, 10-bit colour
// type and the helpers that unpack FIFO words and build the test-pattern bars.
package vga_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int H_FP_LEN   = 16;
    localparam int H_SYNC_LEN = 96;
    localparam int H_BP_LEN   = 48;
    localparam int H_TOTAL    = H_ACTIVE + H_FP_LEN + H_SYNC_LEN + H_BP_LEN;

    localparam int V_ACTIVE   = 480;
    localparam int V_FP_LEN   = 10;
    localparam int V_SYNC_LEN = 2;
    localparam int V_BP_LEN   = 33;
    localparam int V_TOTAL    = V_ACTIVE + V_FP_LEN + V_SYNC_LEN + V_BP_LEN;

    // Wide enough for both H_TOTAL (800) and V_TOTAL (525)
    localparam int CNT_W = 10;

    // Phase of a line; the vertical FSM reuses the same four phases per frame
    typedef enum logic [1:0] {
        H_ACT  = 2'd0,
        H_FP   = 2'd1,
        H_SYNC = 2'd2,
        H_BP   = 2'd3
    } h_phase_t;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } rgb10_t;

    // FIFO1 = {x, G[9:5], B[9:0]}, FIFO2 = {x, G[4:0], R[9:0]}; bit 15 is don't-care
    function automatic rgb10_t unpack_rgb(input logic [15:0] d1, input logic [15:0] d2);
        rgb10_t p;
        p.r = d2[9:0];
        p.g = {d1[14:10], d2[14:10]};
        p.b = d1[9:0];
        return p;
    endfunction

    // Full-scale colour of bar 0..7: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [23:0] bar_rgb(input logic [2:0] bar);
        logic [2:0] m;
        case (bar)
            3'd0:    m = 3'b111;
            3'd1:    m = 3'b110;
            3'd2:    m = 3'b011;
            3'd3:    m = 3'b010;
            3'd4:    m = 3'b101;
            3'd5:    m = 3'b100;
            3'd6:    m = 3'b001;
            default: m = 3'b000;
        endcase
        return {{8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel/line counters plus horizontal and vertical phase FSMs.
// Produces raw (undelayed) active, in-sync flags and the last-pixel-of-frame strobe.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE_PX = H_ACTIVE,
    parameter int H_FP_PX     = H_FP_LEN,
    parameter int H_SYNC_PX   = H_SYNC_LEN,
    parameter int H_BP_PX     = H_BP_LEN,
    parameter int V_ACTIVE_LN = V_ACTIVE,
    parameter int V_FP_LN     = V_FP_LEN,
    parameter int V_SYNC_LN   = V_SYNC_LEN,
    parameter int V_BP_LN     = V_BP_LEN
)(
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] h_cnt,
    output logic             active,
    output logic             h_sync,
    output logic             v_sync,
    output logic             frame_end
);

    localparam int HT = H_ACTIVE_PX + H_FP_PX + H_SYNC_PX + H_BP_PX;
    localparam int VT = V_ACTIVE_LN + V_FP_LN + V_SYNC_LN + V_BP_LN;

    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE_PX - 1);
    localparam logic [CNT_W-1:0] H_FP_END   = CNT_W'(H_ACTIVE_PX + H_FP_PX - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE_PX + H_FP_PX + H_SYNC_PX - 1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(HT - 1);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE_LN - 1);
    localparam logic [CNT_W-1:0] V_FP_END   = CNT_W'(V_ACTIVE_LN + V_FP_LN - 1);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE_LN + V_FP_LN + V_SYNC_LN - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(VT - 1);

    logic [CNT_W-1:0] v_cnt;
    h_phase_t         h_ph, h_ph_nxt;
    h_phase_t         v_ph, v_ph_nxt;
    logic             line_end;

    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);
    assign active    = (h_ph == H_ACT) && (v_ph == H_ACT);
    assign h_sync    = (h_ph == H_SYNC);
    assign v_sync    = (v_ph == H_SYNC);

    // Raster counters: h wraps every line and advances v, v wraps every frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= line_end ? '0 : h_cnt + 1'b1;
            if (line_end)
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end
    end

    // Phase state registers, kept in step with the counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_ph <= H_ACT;
            v_ph <= H_ACT;
        end else begin
            h_ph <= h_ph_nxt;
            v_ph <= v_ph_nxt;
        end
    end

    // Horizontal phase advances on the last pixel of each phase
    always_comb begin
        h_ph_nxt = h_ph;
        case (h_ph)
            H_ACT:   if (h_cnt == H_ACT_END)  h_ph_nxt = H_FP;
            H_FP:    if (h_cnt == H_FP_END)   h_ph_nxt = H_SYNC;
            H_SYNC:  if (h_cnt == H_SYNC_END) h_ph_nxt = H_BP;
            H_BP:    if (line_end)            h_ph_nxt = H_ACT;
            default:                          h_ph_nxt = H_ACT;
        endcase
    end

    // Vertical phase advances only at end of line, on the last line of each phase
    always_comb begin
        v_ph_nxt = v_ph;
        if (line_end) begin
            case (v_ph)
                H_ACT:   if (v_cnt == V_ACT_END)  v_ph_nxt = H_FP;
                H_FP:    if (v_cnt == V_FP_END)   v_ph_nxt = H_SYNC;
                H_SYNC:  if (v_cnt == V_SYNC_END) v_ph_nxt = H_BP;
                H_BP:    if (v_cnt == V_LAST)     v_ph_nxt = H_ACT;
                default:                          v_ph_nxt = H_ACT;
            endcase
        end
    end

endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: VGA raster generator reading the SDRAM frame-buffer FIFOs.
// Requests one FIFO word pair per visible pixel, unpacks to 10-bit RGB and drives
// the DAC pins two cycles after the counter position they belong to.
// Optional build macro VGA_TEST_PATTERN_EN: with display disabled, show eight
// vertical colour bars instead of black.
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int H_ACTIVE_PX = H_ACTIVE,
    parameter int H_FP_PX     = H_FP_LEN,
    parameter int H_SYNC_PX   = H_SYNC_LEN,
    parameter int H_BP_PX     = H_BP_LEN,
    parameter int V_ACTIVE_LN = V_ACTIVE,
    parameter int V_FP_LN     = V_FP_LEN,
    parameter int V_SYNC_LN   = V_SYNC_LEN,
    parameter int V_BP_LN     = V_BP_LEN
)(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic [15:0] i_rd_data1,
    input  logic [15:0] i_rd_data2,
    output logic        o_rd_req,
    output logic        o_frame_start,
    output logic [7:0]  o_VGA_R,
    output logic [7:0]  o_VGA_G,
    output logic [7:0]  o_VGA_B,
    output logic        o_H_sync,
    output logic        o_V_sync,
    output logic        o_VGA_BLANK_N
);

    logic [CNT_W-1:0] h_cnt;
    logic             act, hs, vs, frame_end;
    logic             frame_en;
    logic             vld_p0, en_p0, hs_p0, vs_p0;
    rgb10_t           px;
    logic [23:0]      rgb_nxt;
    logic             unused_bits;

    vga_timing #(
        .H_ACTIVE_PX (H_ACTIVE_PX),
        .H_FP_PX     (H_FP_PX),
        .H_SYNC_PX   (H_SYNC_PX),
        .H_BP_PX     (H_BP_PX),
        .V_ACTIVE_LN (V_ACTIVE_LN),
        .V_FP_LN     (V_FP_LN),
        .V_SYNC_LN   (V_SYNC_LN),
        .V_BP_LN     (V_BP_LN)
    ) u_timing (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .h_cnt     (h_cnt),
        .active    (act),
        .h_sync    (hs),
        .v_sync    (vs),
        .frame_end (frame_end)
    );

    // FIFO pops happen in the same cycle as the counter position so data lands one cycle later
    assign o_rd_req      = frame_en & act;
    assign o_frame_start = frame_end;
    assign px            = unpack_rgb(i_rd_data1, i_rd_data2);

    // Display enable is only re-sampled on the last pixel so a frame is never torn
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            frame_en <= 1'b0;
        else if (frame_end)
            frame_en <= i_enable;
    end

    // stage p0: control for the pixel whose FIFO words are on the inputs next cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vld_p0 <= 1'b0;
            en_p0  <= 1'b0;
            hs_p0  <= 1'b0;
            vs_p0  <= 1'b0;
        end else begin
            vld_p0 <= act;
            en_p0  <= frame_en;
            hs_p0  <= hs;
            vs_p0  <= vs;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE_PX / 8;

    logic [2:0] bar_idx, bar_p0;

    // Which of the eight equal-width bars the current column falls in
    always_comb begin
        bar_idx = '0;
        for (int i = 1; i < 8; i++)
            if (h_cnt >= CNT_W'(i * BAR_W))
                bar_idx = 3'(i);
    end

    // stage p0: bar index travels with the pixel's control bits
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            bar_p0 <= '0;
        else
            bar_p0 <= bar_idx;
    end
`endif

    // Pixel colour: FIFO data when displaying, otherwise black (or bars when enabled)
    always_comb begin
        rgb_nxt = '0;
        if (vld_p0 && en_p0)
            rgb_nxt = {px.r[9:2], px.g[9:2], px.b[9:2]};
`ifdef VGA_TEST_PATTERN_EN
        else if (vld_p0)
            rgb_nxt = bar_rgb(bar_p0);
`endif
    end

    // stage p1: pin registers, sync/blank aligned with colour
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_VGA_R       <= '0;
            o_VGA_G       <= '0;
            o_VGA_B       <= '0;
            o_H_sync      <= 1'b1;
            o_V_sync      <= 1'b1;
            o_VGA_BLANK_N <= 1'b0;
        end else begin
            {o_VGA_R, o_VGA_G, o_VGA_B} <= rgb_nxt;
            o_H_sync      <= ~hs_p0;
            o_V_sync      <= ~vs_p0;
            o_VGA_BLANK_N <= vld_p0;
        end
    end

    // Word bit 15, the two dropped LSBs per channel and the column count (bars only) go nowhere
    assign unused_bits = ^{i_rd_data1[15], i_rd_data2[15], px.r[1:0], px.g[1:0], px.b[1:0], h_cnt};

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: directed bench for vga_frame_reader on a reduced raster
// (25 px x 10 lines per frame) so several whole frames fit in a short run.
module tb_vga_frame_reader;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic        clk = 1'b0;
    logic        i_rst_n, i_enable;
    logic [15:0] i_rd_data1, i_rd_data2;
    logic        o_rd_req, o_frame_start, o_H_sync, o_V_sync, o_VGA_BLANK_N;
    logic [7:0]  o_VGA_R, o_VGA_G, o_VGA_B;

    vga_frame_reader #(
        .H_ACTIVE_PX (HA), .H_FP_PX (HF), .H_SYNC_PX (HS), .H_BP_PX (HB),
        .V_ACTIVE_LN (VA), .V_FP_LN (VF), .V_SYNC_LN (VS), .V_BP_LN (VB)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .i_enable      (i_enable),
        .i_rd_data1    (i_rd_data1),
        .i_rd_data2    (i_rd_data2),
        .o_rd_req      (o_rd_req),
        .o_frame_start (o_frame_start),
        .o_VGA_R       (o_VGA_R),
        .o_VGA_G       (o_VGA_G),
        .o_VGA_B       (o_VGA_B),
        .o_H_sync      (o_H_sync),
        .o_V_sync      (o_V_sync),
        .o_VGA_BLANK_N (o_VGA_BLANK_N)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic       act;
        logic       en;
        logic       hs;
        logic       vs;
        logic [9:0] h;
    } px_state_t;

    int        n_checks = 0, n_pass = 0;
    int        cyc;
    logic      en_m;
    px_state_t s1, s2;
    logic [15:0] dprev1, dprev2;
    int        m_rd, m_fs, m_hs, m_vs, m_bl, m_rgb;
    int        rd_cnt, fs_cnt, first_fs, vs_low_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [23:0] exp_pix(input logic [15:0] d1, input logic [15:0] d2);
        logic [9:0] r, g, b;
        r = d2[9:0];
        g = {d1[14:10], d2[14:10]};
        b = d1[9:0];
        return {r[9:2], g[9:2], b[9:2]};
    endfunction

`ifdef VGA_TEST_PATTERN_EN
    function automatic logic [23:0] exp_bar(input logic [9:0] h);
        logic [23:0] tbl [8];
        tbl[0] = 24'hFFFFFF; tbl[1] = 24'hFFFF00; tbl[2] = 24'h00FFFF; tbl[3] = 24'h00FF00;
        tbl[4] = 24'hFF00FF; tbl[5] = 24'hFF0000; tbl[6] = 24'h0000FF; tbl[7] = 24'h000000;
        return tbl[int'(h) / (HA / 8)];
    endfunction
`endif

    task automatic clear_counts();
        m_rd = 0; m_fs = 0; m_hs = 0; m_vs = 0; m_bl = 0; m_rgb = 0;
        rd_cnt = 0; fs_cnt = 0; first_fs = -1; vs_low_cnt = 0;
    endtask

    task automatic model_reset();
        cyc = 0; en_m = 1'b0; s1 = '0; s2 = '0; dprev1 = '0; dprev2 = '0;
        clear_counts();
    endtask

    // Compare one cycle against the raster model, then advance to the next cycle
    task automatic tick();
        int h, v;
        logic act;
        logic [23:0] erg;
        h = cyc % HT;
        v = (cyc / HT) % VT;
        act = (h < HA) && (v < VA);
        if (o_rd_req !== (en_m && act)) m_rd++;
        if (o_rd_req === 1'b1) rd_cnt++;
        if (o_frame_start !== ((h == HT - 1) && (v == VT - 1))) m_fs++;
        if (o_frame_start === 1'b1) begin
            fs_cnt++;
            if (first_fs < 0) first_fs = cyc;
        end
        if (o_H_sync !== !s2.hs) m_hs++;
        if (o_V_sync !== !s2.vs) m_vs++;
        if (o_V_sync === 1'b0) vs_low_cnt++;
        if (o_VGA_BLANK_N !== s2.act) m_bl++;
        erg = '0;
        if (s2.act && s2.en) erg = exp_pix(dprev1, dprev2);
`ifdef VGA_TEST_PATTERN_EN
        else if (s2.act) erg = exp_bar(s2.h);
`endif
        if ({o_VGA_R, o_VGA_G, o_VGA_B} !== erg) m_rgb++;
        s2 = s1;
        s1.act = act;
        s1.en  = en_m;
        s1.hs  = (h >= HA + HF) && (h < HA + HF + HS);
        s1.vs  = (v >= VA + VF) && (v < VA + VF + VS);
        s1.h   = 10'(h);
        dprev1 = i_rd_data1;
        dprev2 = i_rd_data2;
        if ((h == HT - 1) && (v == VT - 1)) en_m = i_enable;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            i_rd_data1 = 16'($urandom);
            i_rd_data2 = 16'($urandom);
            tick();
        end
    endtask

    task automatic frame_checks(input string tag, input int exp_rd, input int exp_fs);
        check({tag, "_rd_req_pattern"}, m_rd, 0);
        check({tag, "_rd_req_count"}, rd_cnt, exp_rd);
        check({tag, "_frame_start_pos"}, m_fs, 0);
        check({tag, "_frame_start_count"}, fs_cnt, exp_fs);
        check({tag, "_hsync"}, m_hs, 0);
        check({tag, "_vsync"}, m_vs, 0);
        check({tag, "_blank_n"}, m_bl, 0);
        check({tag, "_rgb"}, m_rgb, 0);
        clear_counts();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rd_req"}, o_rd_req, 0);
        check({tag, "_frame_start"}, o_frame_start, 0);
        check({tag, "_R"}, o_VGA_R, 0);
        check({tag, "_G"}, o_VGA_G, 0);
        check({tag, "_B"}, o_VGA_B, 0);
        check({tag, "_hsync"}, o_H_sync, 1);
        check({tag, "_vsync"}, o_V_sync, 1);
        check({tag, "_blank_n"}, o_VGA_BLANK_N, 0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_enable = 1'b1;
        i_rd_data1 = '0;
        i_rd_data2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        model_reset();
        i_rst_n = 1'b1;

        // frame 0: black after reset, enable latched on its last pixel
        run(FR);
        check("f0_first_frame_start_cycle", first_fs, FR - 1);
        frame_checks("f0", 0, 1);

        // frame 1: enabled, two hand-computed words at pixel (5,2) and (6,2)
        run(2 * HT + 6);
        i_rd_data1 = 16'h2804;
        i_rd_data2 = 16'h57FC;
        tick();
        check("unpack1_R", o_VGA_R, 8'hFF);
        check("unpack1_G", o_VGA_G, 8'h55);
        check("unpack1_B", o_VGA_B, 8'h01);
        check("unpack1_blank_n", o_VGA_BLANK_N, 1);
        i_rd_data1 = 16'hFFFF;
        i_rd_data2 = 16'h0000;
        tick();
        check("unpack2_R", o_VGA_R, 8'h00);
        check("unpack2_G", o_VGA_G, 8'hF8);
        check("unpack2_B", o_VGA_B, 8'hFF);
        run(FR - (2 * HT + 8));
        frame_checks("f1", HA * VA, 1);

        // frame 2: enable dropped on line 2 still finishes the frame
        run(2 * HT);
        i_enable = 1'b0;
        run(FR - 2 * HT);
        frame_checks("f2", HA * VA, 1);

        // frame 3: disabled; mid-frame toggles ignored, final value 1 latched at the end
        run(3 * HT);
        i_enable = 1'b1;
        run(2 * HT);
        i_enable = 1'b0;
        run(3 * HT);
        i_enable = 1'b1;
        run(2 * HT);
        frame_checks("f3", 0, 1);

        // frame 4: enabled, reset asserted at pixel (12,4)
        run(4 * HT + 12);
        check("pre_reset_rd_req", o_rd_req, 1);
        check("pre_reset_blank_n", o_VGA_BLANK_N, 1);
        frame_checks("f4_partial", 4 * HA + 12, 0);
        i_rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset("midrst");
        model_reset();
        i_rst_n = 1'b1;

        // frame after reset restarts at (0,0) and is black
        run(FR);
        check("fr_first_frame_start_cycle", first_fs, FR - 1);
        check("fr_vsync_low_cycles", vs_low_cnt, VS * HT);
        frame_checks("fr", 0, 1);

        // next frame picks up the enable latched at the wrap
        run(FR);
        frame_checks("fr1", HA * VA, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
